transpose_sequencer: RTL
========================

Name: transpose_sequencer

Overview:
Sequences the 4x4-byte matrix transpose datapath against the vector register file. On a start handshake it reads vecSize consecutive vector registers and holds them in an internal matrix buffer. It then writes the vecSize transposed rows back to a destination register range. Sits in the execute stage and shares the register file read and write ports with the rest of the pipeline, using an enable/ready handshake.

Parameters:
regSize, 32, width of one vector register in bits; fixed at 32 because the transpose datapath is byte-lane based.
vecSize, 4, number of rows/registers in the matrix; fixed at 4.
addrWidth, 4, register-file index width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start_valid  input  1  request to transpose
start_ready  output  1  high only in IDLE; a start is accepted when start_valid & start_ready
src_base  input  addrWidth  first source register; sampled on accept
dst_base  input  addrWidth  first destination register; sampled on accept
rf_rd_en  output  1  read request
rf_rd_addr  output  addrWidth  read index
rf_rd_data  input  regSize  read data, valid exactly 1 cycle after rf_rd_en
rf_wr_en  output  1  write request
rf_wr_addr  output  addrWidth  write index
rf_wr_data  output  regSize  transposed row
rf_wr_ready  input  1  a write completes in a cycle where rf_wr_en & rf_wr_ready
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last write completes

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE and counters clear. Buffer and latched bases clear to 0. All outputs are 0 except start_ready, which is 1.
- States: IDLE -> READ -> WRITE -> DONE -> IDLE.
- IDLE:
  - start_ready = 1.
  - On accept, latch src_base and dst_base, set cnt = 0 and go to READ.
- READ: lasts exactly vecSize+1 = 5 cycles, cnt 0..4.
  - For cnt < 4: rf_rd_en = 1 and rf_rd_addr = src_base + cnt.
  - For cnt >= 1: capture rf_rd_data into buf[cnt-1].
  - At cnt = 4: clear cnt and go to WRITE.
- WRITE:
  - rf_wr_en = 1, rf_wr_addr = dst_base + cnt, rf_wr_data = transposed[cnt].
  - cnt advances only when rf_wr_ready = 1. When rf_wr_ready = 0, addr and data hold stable.
  - After the write with cnt = 3 completes, go to DONE.
- DONE: done = 1 for one cycle, then return to IDLE.
- transposed[r] = {buf[0] byte(3-r), buf[1] byte(3-r), buf[2] byte(3-r), buf[3] byte(3-r)}, where byte 3 = bits 31:24. Element [i][j] moves to [j][i].
- Latency: with rf_wr_ready tied high, accept edge at cycle 0 gives reads issued in cycles 1-4, writes in cycles 6-9, and done in cycle 10. The next start can be accepted in cycle 11.
- Address arithmetic is modulo 2^addrWidth. Example: base 14 with addrWidth 4 accesses 14, 15, 0, 1.
- src_base == dst_base, or any overlap between the two ranges, is legal: all reads complete before the first write.
- start_valid while busy is ignored. start_ready = 0 and nothing is queued.
- No read and write are ever issued in the same cycle.
- rst asserted mid-operation aborts immediately. No further writes are issued and a partially written destination is left as-is. done is not pulsed.
- rf_rd_addr, rf_wr_addr and rf_wr_data drive 0 whenever their enable is low.

Decomposition:
- Shared execute-stage package holds:
  - the state enum {IDLE, READ, WRITE, DONE};
  - constants VEC_SIZE = 4, REG_SIZE = 32, BYTE_W = 8;
  - a matrix typedef: array [VEC_SIZE] of logic [REG_SIZE-1:0].
- One sub-module: the existing matrix_transpose combinational unit, instantiated once on the buffer.
- The sequencer owns the buffer, counter and FSM.

Test Plan:
- Basic: R2..R5 = 0x00010203, 0x10111213, 0x20212223, 0x30313233; src=2, dst=8, rf_wr_ready=1 -> writes R8=0x00102030, R9=0x01112131, R10=0x02122232, R11=0x03132333 in cycles 6-9; done in cycle 10.
- In-place: src=dst=2 with the same data -> R2..R5 end as the transposed values above. All 4 reads precede the first write.
- Write backpressure: rf_wr_ready low for 3 cycles during the row-1 write -> rf_wr_addr stays 9 and rf_wr_data stays 0x01112131 while stalled. Row order is preserved and done is delayed by exactly 3 cycles.
- Wrap: src=14, dst=15 -> reads 14, 15, 0, 1; writes 15, 0, 1, 2.
- Busy start: start_valid pulsed in cycle 3 with src=7 -> not accepted, start_ready=0, and only the original 4 writes occur.
- Reset mid-WRITE: rst asserted after 2 writes -> rf_wr_en drops to 0 immediately, no done pulse, start_ready=1, busy=0. A new start then completes normally.

Source files
------------

// File: rtl/transpose_sequencer_pkg.sv
// Shared execute-stage types for the 4x4-byte matrix transpose path.
package transpose_sequencer_pkg;
  localparam int VEC_SIZE = 4;
  localparam int REG_SIZE = 32;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] matrix_t;
endpackage

// File: rtl/matrix_transpose.sv
// Combinational 4x4-byte transpose: element [i][j] moves to [j][i], byte 3 is the MSB lane.
module matrix_transpose
  import transpose_sequencer_pkg::*;
(
  input  matrix_t mat,
  output matrix_t trans
);
  always_comb begin
    trans = '0;
    for (int r = 0; r < VEC_SIZE; r++) begin
      for (int c = 0; c < VEC_SIZE; c++) begin
        trans[r][(VEC_SIZE-1-c)*BYTE_W +: BYTE_W] = mat[c][(VEC_SIZE-1-r)*BYTE_W +: BYTE_W];
      end
    end
  end
endmodule

// File: rtl/transpose_sequencer.sv
// Reads four source registers into a buffer, then writes the transposed rows back.
// Handshakes: start accepted on start_valid & start_ready; a write completes on rf_wr_en & rf_wr_ready.
module transpose_sequencer
  import transpose_sequencer_pkg::*;
#(
  parameter int regSize   = 32,
  parameter int vecSize   = 4,
  parameter int addrWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [addrWidth-1:0] src_base,
  input  logic [addrWidth-1:0] dst_base,
  output logic                 rf_rd_en,
  output logic [addrWidth-1:0] rf_rd_addr,
  input  logic [regSize-1:0]   rf_rd_data,
  output logic                 rf_wr_en,
  output logic [addrWidth-1:0] rf_wr_addr,
  output logic [regSize-1:0]   rf_wr_data,
  input  logic                 rf_wr_ready,
  output logic                 busy,
  output logic                 done
);
  localparam logic [2:0] LAST_RD = 3'(vecSize);
  localparam logic [2:0] LAST_WR = 3'(vecSize - 1);

  state_t                 state;
  logic [2:0]             cnt;
  logic [addrWidth-1:0]   src;
  logic [addrWidth-1:0]   dst;
  matrix_t                mat_buf;
  matrix_t                trans;
  logic [1:0]             cap_row;

  matrix_transpose u_transpose (
    .mat   (mat_buf),
    .trans (trans)
  );

  // Read data lags the request by one cycle, so the row captured is cnt-1.
  assign cap_row = cnt[1:0] - 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      src     <= '0;
      dst     <= '0;
      mat_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            src   <= src_base;
            dst   <= dst_base;
            cnt   <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (cnt != 3'd0) mat_buf[cap_row] <= rf_rd_data;
          if (cnt == LAST_RD) begin
            cnt   <= '0;
            state <= WRITE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WRITE: begin
          if (rf_wr_ready) begin
            if (cnt == LAST_WR) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign rf_rd_en    = (state == READ) && (cnt < LAST_RD);
  assign rf_rd_addr  = rf_rd_en ? src + addrWidth'(cnt) : '0;
  assign rf_wr_en    = (state == WRITE);
  assign rf_wr_addr  = rf_wr_en ? dst + addrWidth'(cnt) : '0;
  assign rf_wr_data  = rf_wr_en ? trans[cnt[1:0]] : '0;
endmodule
